// File: rtl/fp_unpack_stage.sv
// fp_unpack_stage
//   Unpacks a pair of IEEE-754 single-precision operands into a 37-bit
//   internal format and classifies the pair for the downstream adder path.
//   Unpacked format: [36] sign, [35:28] exponent, [27] hidden bit,
//   [26:4] fraction, [3:0] guard bits (always zero).
//
// Ports
//   clk       : rising-edge clock for all state
//   rst       : synchronous active-high reset
//   in_valid  : operand pair A/B is presented
//   in_ready  : stage can accept a pair this cycle (registered, = skid empty)
//   A, B      : IEEE-754 single-precision operands
//   out_valid : NA/NB/edata hold a valid result
//   out_ready : downstream accepts the result
//   NA, NB    : unpacked operands
//   edata     : path class (10 special, 01 zero operand, 00 ordinary)
//   op_count  : number of accepted pairs since reset (wraps)
module fp_unpack_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [36:0] NA,
  output logic [36:0] NB,
  output logic [1:0]  edata,
  output logic [15:0] op_count
);

  // Denormals take exponent 1 with a clear hidden bit so they line up with
  // the smallest normal; zero keeps its sign; exp 255 passes through with
  // the hidden bit set and the fraction untouched.
  function automatic logic [36:0] unpack_op(input logic [31:0] x);
    logic [7:0]  exp_f;
    logic [22:0] frac_f;
    exp_f  = x[30:23];
    frac_f = x[22:0];
    if (exp_f == 8'd0) begin
      if (frac_f == 23'd0) begin
        unpack_op = {x[31], 8'd0, 1'b0, 23'd0, 4'd0};
      end else begin
        unpack_op = {x[31], 8'd1, 1'b0, frac_f, 4'd0};
      end
    end else begin
      unpack_op = {x[31], exp_f, 1'b1, frac_f, 4'd0};
    end
  endfunction

  // Special operands take priority over zero operands.
  function automatic logic [1:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic a_special, b_special, a_zero, b_zero;
    a_special = (a[30:23] == 8'hFF);
    b_special = (b[30:23] == 8'hFF);
    a_zero    = (a[30:0] == 31'd0);
    b_zero    = (b[30:0] == 31'd0);
    if (a_special || b_special) begin
      classify = 2'b10;
    end else if (a_zero || b_zero) begin
      classify = 2'b01;
    end else begin
      classify = 2'b00;
    end
  endfunction

  logic        main_valid_q, main_valid_d;
  logic [36:0] main_na_q, main_na_d;
  logic [36:0] main_nb_q, main_nb_d;
  logic [1:0]  main_ed_q, main_ed_d;
  logic        skid_valid_q, skid_valid_d;
  logic [36:0] skid_na_q, skid_na_d;
  logic [36:0] skid_nb_q, skid_nb_d;
  logic [1:0]  skid_ed_q, skid_ed_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] op_count_q, op_count_d;

  logic        accept;
  logic        main_free;
  logic [36:0] new_na;
  logic [36:0] new_nb;
  logic [1:0]  new_ed;

  // The main register refills whenever it is empty or draining: the skid
  // entry (older) always goes first, otherwise the incoming pair goes
  // straight in. A pair arriving while main is stalled lands in the skid.
  // in_ready can only be high while the skid is empty, so an accept never
  // coincides with a full skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_na_d    = main_na_q;
    main_nb_d    = main_nb_q;
    main_ed_d    = main_ed_q;
    skid_valid_d = skid_valid_q;
    skid_na_d    = skid_na_q;
    skid_nb_d    = skid_nb_q;
    skid_ed_d    = skid_ed_q;

    accept    = in_valid && in_ready_q;
    main_free = !main_valid_q || out_ready;
    new_na    = unpack_op(A);
    new_nb    = unpack_op(B);
    new_ed    = classify(A, B);

    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_na_d    = skid_na_q;
        main_nb_d    = skid_nb_q;
        main_ed_d    = skid_ed_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_na_d    = new_na;
        main_nb_d    = new_nb;
        main_ed_d    = new_ed;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_na_d    = new_na;
      skid_nb_d    = new_nb;
      skid_ed_d    = new_ed;
    end

    in_ready_d = !skid_valid_d;
    op_count_d = accept ? op_count_q + 16'd1 : op_count_q;
  end

  // Reset discards any pending pairs and zeroes the visible result so the
  // outputs are never X even before the first transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_na_q    <= 37'd0;
      main_nb_q    <= 37'd0;
      main_ed_q    <= 2'b00;
      skid_valid_q <= 1'b0;
      skid_na_q    <= 37'd0;
      skid_nb_q    <= 37'd0;
      skid_ed_q    <= 2'b00;
      in_ready_q   <= 1'b1;
      op_count_q   <= 16'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_na_q    <= main_na_d;
      main_nb_q    <= main_nb_d;
      main_ed_q    <= main_ed_d;
      skid_valid_q <= skid_valid_d;
      skid_na_q    <= skid_na_d;
      skid_nb_q    <= skid_nb_d;
      skid_ed_q    <= skid_ed_d;
      in_ready_q   <= in_ready_d;
      op_count_q   <= op_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign NA        = main_na_q;
  assign NB        = main_nb_q;
  assign edata     = main_ed_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/fp_unpack_stage.md
FP_UNPACK_STAGE -- requirements
Module: fp_unpack_stage

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: in_valid  in  1  operand pair A/B is presented.
REQ-004 SHALL have: in_ready  out  1  stage can accept a pair this cycle.
REQ-005 SHALL have: A  in  32  IEEE-754 single operand A.
REQ-006 SHALL have: B  in  32  IEEE-754 single operand B.
REQ-007 SHALL have: out_valid  out  1  NA/NB/edata hold a valid result.
REQ-008 SHALL have: out_ready  in  1  downstream operand router accepts the result.
REQ-009 SHALL have: NA  out  37  unpacked operand A.
REQ-010 SHALL have: NB  out  37  unpacked operand B.
REQ-011 SHALL have: edata  out  2  path class selecting the downstream adder path.
REQ-012 SHALL have: op_count  out  16  count of pairs accepted since reset.

Function
REQ-013 37-bit layout SHALL be: [36] sign, [35:28] exponent, [27] hidden bit, [26:4] fraction, [3:0] guard bits = 0000.
REQ-014 Normal (exp 1..254): exponent = field, hidden = 1.
REQ-015 Denormal (exp 0, frac != 0): exponent = 8'd1, hidden = 0.
REQ-016 Zero (exp 0, frac 0): exponent = 0, hidden = 0, sign preserved.
REQ-017 Inf/NaN (exp 255): exponent = 255, hidden = 1, fraction passed unchanged.
REQ-018 edata SHALL be 2'b10 if either operand has exp 255, else 2'b01 if either operand is zero, else 2'b00; 2'b11 is never produced.
REQ-019 Handshake: a transfer occurs on a rising edge where valid && ready; in_valid/A/B are not required to be held by this block's view beyond the transfer cycle.
REQ-020 Latency: a pair accepted in cycle N SHALL appear on NA/NB/edata with out_valid = 1 in cycle N+1 when the output stage is empty or draining.
REQ-021 Storage: a main output register plus one skid register; in_ready SHALL be a registered signal equal to "skid register empty".
REQ-022 Accept while main full and out_ready = 0: pair goes to the skid register; in_ready drops the next cycle.
REQ-023 out_ready = 1 with skid full: skid contents move to main register the same edge; in_ready returns to 1 the next cycle.
REQ-024 Simultaneous accept and output transfer with skid empty: the new pair SHALL load directly into main; out_valid stays 1 without a bubble.
REQ-025 NA/NB/edata SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-026 Ordering SHALL be strict FIFO; no pair is dropped or duplicated.
REQ-027 op_count SHALL increment by 1 on every input transfer and wrap from 16'hFFFF to 16'h0000.
REQ-028 When out_valid = 0, NA/NB/edata values are don't-care but SHALL NOT be X in simulation (hold last value).

Reset
REQ-029 While rst = 1 on a clock edge: out_valid = 0, skid empty, in_ready = 1 (from the following cycle), op_count = 0, NA = NB = 0, edata = 2'b00.
REQ-030 Reset mid-operation SHALL discard main and skid contents; no pending pair is emitted after reset deasserts.
REQ-031 An in_valid asserted in the same cycle as rst SHALL NOT be accepted or counted.

Verification
REQ-032 A=0x3F800000, B=0x40000000, out_ready=1 -> next cycle NA=37'h07F8000000, NB=37'h0808000000, edata=00, op_count=1.
REQ-033 A=0x00000000, B=0x3F800000 -> edata=01, NA=0; A=0x7FC00000 (NaN), B=0x00000000 -> edata=10 (special wins over zero).
REQ-034 A=0x00000001 (denormal) -> NA=37'h0010000010 (exponent 1, hidden 0, fraction LSB at bit 4).
REQ-035 out_ready held 0, three back-to-back pairs offered -> pairs 1,2 accepted, in_ready=0 for pair 3; release out_ready -> outputs 1,2,3 in order, no loss, op_count=3.
REQ-036 Continuous in_valid=1/out_ready=1 for 100 cycles -> one result per cycle, out_valid never drops after the first, op_count=100.
REQ-037 rst pulsed with main and skid full -> next cycle out_valid=0, in_ready=1, op_count=0; no stale result ever appears.
